cacheline_mem_arbiter: RTL and testbench
========================================

Name: cacheline_mem_arbiter

Overview:
- Shares the single 64-bit burst DRAM port between the icache (read-only) and the dcache (read/write) at 256-bit cacheline granularity.
- Performs arbitration and burst sequencing: 4-beat read gather and 4-beat write scatter.
- Returns one-cycle responses to the winning cache.
- Sits between both caches and the memory model; replaces the per-cache adapters.

Parameters:
- BEATS, 4, beats per cacheline (64-bit each); fixed, 256/64.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_addr  in  32  icache line address
- i_read  in  1  icache read request, held until i_resp
- i_rdata  out  256  icache line data, valid with i_resp
- i_resp  out  1  icache one-cycle completion pulse
- d_addr  in  32  dcache line address
- d_read  in  1  dcache read request, held until d_resp
- d_write  in  1  dcache writeback request, held until d_resp
- d_wdata  in  256  dcache writeback line
- d_rdata  out  256  dcache line data, valid with d_resp
- d_resp  out  1  dcache one-cycle completion pulse
- dfp_addr  out  32  memory address, low 5 bits forced to 0
- dfp_read  out  1  memory read command
- dfp_write  out  1  memory write beat valid
- dfp_wdata  out  64  write beat data
- dfp_ready  in  1  memory accepts command/beat this cycle
- dfp_raddr  in  32  address tag of returning read beat
- dfp_rdata  in  64  read beat data
- dfp_rvalid  in  1  read beat valid

Behaviour:
- Reset (clk, rst synchronous active-high):
  - state=IDLE, beat count=0, last_grant=ICACHE, so the dcache wins the first tie.
  - All resp/dfp_read/dfp_write outputs 0; rdata outputs 0.
- One transaction outstanding at a time. States: IDLE, RD_CMD, RD_BURST, WR_BURST, RESP.
- IDLE arbitration:
  - Only one requester pending -> grant it.
  - Both pending -> grant the one not equal to last_grant (round-robin).
  - Latch grant, {addr[31:5],5'b0}, op, and d_wdata (for writes).
  - Next state: RD_CMD for reads, WR_BURST for writes.
- dcache op conflict: d_read and d_write both high -> treat as write.
- RD_CMD:
  - Drive dfp_read=1 and dfp_addr=latched addr.
  - Stay until dfp_ready=1, then go to RD_BURST with count=0.
- RD_BURST:
  - Drive dfp_read=0.
  - Each beat with dfp_rvalid=1 and dfp_raddr==latched addr writes dfp_rdata into line[count*64 +: 64], then count++.
  - Beats with a mismatched raddr are ignored.
  - After the 4th beat (count==3 accepted) -> RESP.
- WR_BURST:
  - Drive dfp_write=1, dfp_addr=latched addr, dfp_wdata=wline[count*64 +: 64].
  - Advance count only when dfp_ready=1.
  - After the 4th accepted beat -> RESP. dfp_write drops the cycle after.
- RESP:
  - Pulse the granted x_resp=1 for exactly one cycle.
  - x_rdata=assembled line (reads; writes drive 0).
  - Update last_grant. Next state IDLE.
- Latency:
  - Read: resp one cycle after the 4th rvalid beat.
  - Write: resp one cycle after the 4th ready beat.
  - Minimum read = 1 (IDLE) + 1 (cmd) + 4 + 1 = 7 cycles.
- Request behaviour around the grant:
  - A requester must hold its request until resp.
  - Deassertion before grant is legal and simply not served.
  - Signals of the non-granted requester are ignored during a transaction.
- Back-to-back: a request still high after its own resp is re-arbitrated in IDLE on the next cycle. The caches drop the request the cycle after resp.
- Reset mid-transaction: abort to IDLE, no resp issued. Stray rvalid beats arriving in IDLE are ignored.
- rvalid during RD_CMD: ignored.
- dfp_rvalid stalls (gaps between beats): count holds; no timeout.

Decomposition:
- Shared package mem_pkg:
  - BEATS, LINE_W=256, BEAT_W=64.
  - Enum arb_state_t {IDLE, RD_CMD, RD_BURST, WR_BURST, RESP}.
  - Enum requester_t {ICACHE, DCACHE}.
- Optional sub-module rr_arbiter2 (2-way round-robin grant from req[1:0] and last_grant).
- Burst gather/scatter stays inline.

Test Plan:
- Single icache read 0x1000_0024: dfp_addr=0x1000_0020 with one dfp_read pulse; beats A,B,C,D -> i_rdata={D,C,B,A}, i_resp one cycle after D, d_resp stays 0.
- Simultaneous i_read and d_read after reset: dcache served first; icache granted in the IDLE cycle after d_resp. Repeat with both held -> grants alternate D,I,D,I.
- dcache write 0x2000_0040, d_wdata={W3,W2,W1,W0}, dfp_ready low on beats 1 and 3 for 2 cycles -> dfp_wdata sequence W0,W1,W2,W3 with each beat held until ready; d_resp after the W3 accept.
- Read with gaps: rvalid beats at cycles +2,+5,+6,+10, plus a mismatched-raddr rvalid injected at +3 -> mismatched beat ignored; correct line assembled; resp at +11.
- rst asserted during beat 2 of a dcache read -> no d_resp; all outputs 0 next cycle; leftover rvalid beats ignored; a new icache read completes correctly.
- d_read and d_write asserted together -> a write burst is issued and no dfp_read occurs.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizes for the cacheline <-> DRAM burst arbiter.
package mem_pkg;

   localparam int BEATS  = 4;
   localparam int BEAT_W = 64;
   localparam int LINE_W = BEATS * BEAT_W;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_BURST,
      WR_BURST,
      RESP
   } arb_state_t;

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } requester_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_arbiter2
   import mem_pkg::*;
(
   input  logic [1:0] i_req,
   input  requester_t i_last,
   output logic       o_valid,
   output requester_t o_gnt
);

   // Pick the winner from the pending set and the previous grant.
   always_comb begin
      o_valid = |i_req;
      o_gnt   = ICACHE;
      if (i_req == 2'b11)
         o_gnt = (i_last == ICACHE) ? DCACHE : ICACHE;
      else if (i_req[1])
         o_gnt = DCACHE;
   end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one 64-bit burst DRAM port between the icache (reads) and the
// dcache (reads and writebacks), one 256-bit line transaction at a time.
module cacheline_mem_arbiter #(
   parameter int BEATS  = mem_pkg::BEATS,
   parameter int ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   // icache side
   input  logic [ADDR_W-1:0]         i_addr,
   input  logic                      i_read,
   output logic [mem_pkg::LINE_W-1:0] i_rdata,
   output logic                      i_resp,
   // dcache side
   input  logic [ADDR_W-1:0]         d_addr,
   input  logic                      d_read,
   input  logic                      d_write,
   input  logic [mem_pkg::LINE_W-1:0] d_wdata,
   output logic [mem_pkg::LINE_W-1:0] d_rdata,
   output logic                      d_resp,
   // memory side
   output logic [ADDR_W-1:0]         dfp_addr,
   output logic                      dfp_read,
   output logic                      dfp_write,
   output logic [mem_pkg::BEAT_W-1:0] dfp_wdata,
   input  logic                      dfp_ready,
   input  logic [ADDR_W-1:0]         dfp_raddr,
   input  logic [mem_pkg::BEAT_W-1:0] dfp_rdata,
   input  logic                      dfp_rvalid
);

   import mem_pkg::*;

   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   arb_state_t          r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_count;
   requester_t          r_last, r_grant;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_is_wr;
   logic [LINE_W-1:0]   r_wline;
   logic [LINE_W-1:0]   r_line;

   logic [1:0]          w_req;
   logic                w_gnt_vld;
   requester_t          w_gnt;
   logic                w_new_wr;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [ADDR_W-1:0]   w_line_addr;
   logic                w_beat_ok;

   // A dcache request with both read and write high is served as a write.
   assign w_req       = {d_read | d_write, i_read};
   assign w_new_wr    = (w_gnt == DCACHE) && d_write;
   assign w_sel_addr  = (w_gnt == DCACHE) ? d_addr : i_addr;
   assign w_line_addr = {w_sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   // Beats tagged for another address are stale traffic and are dropped.
   assign w_beat_ok   = dfp_rvalid && (dfp_raddr == r_addr);

   rr_arbiter2 u_arb (
      .i_req   (w_req),
      .i_last  (r_last),
      .o_valid (w_gnt_vld),
      .o_gnt   (w_gnt)
   );

   // State register; reset aborts any burst without a response.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and output decode.
   always_comb begin
      w_state_nxt = r_state;
      dfp_read    = 1'b0;
      dfp_write   = 1'b0;
      dfp_addr    = '0;
      dfp_wdata   = '0;
      i_resp      = 1'b0;
      d_resp      = 1'b0;
      i_rdata     = '0;
      d_rdata     = '0;
      unique case (r_state)
         IDLE: begin
            if (w_gnt_vld) w_state_nxt = w_new_wr ? WR_BURST : RD_CMD;
         end
         RD_CMD: begin
            dfp_read = 1'b1;
            dfp_addr = r_addr;
            if (dfp_ready) w_state_nxt = RD_BURST;
         end
         RD_BURST: begin
            if (w_beat_ok && r_count == LAST_BEAT) w_state_nxt = RESP;
         end
         WR_BURST: begin
            dfp_write = 1'b1;
            dfp_addr  = r_addr;
            dfp_wdata = r_wline[r_count*BEAT_W +: BEAT_W];
            if (dfp_ready && r_count == LAST_BEAT) w_state_nxt = RESP;
         end
         RESP: begin
            w_state_nxt = IDLE;
            if (r_grant == ICACHE) begin
               i_resp  = 1'b1;
               i_rdata = r_line;
            end else begin
               d_resp  = 1'b1;
               d_rdata = r_is_wr ? '0 : r_line;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Transaction latch, beat counter and line gather.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_last  <= ICACHE;
         r_grant <= ICACHE;
         r_addr  <= '0;
         r_is_wr <= 1'b0;
         r_wline <= '0;
         r_line  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_count <= '0;
               if (w_gnt_vld) begin
                  r_grant <= w_gnt;
                  r_addr  <= w_line_addr;
                  r_is_wr <= w_new_wr;
                  r_line  <= '0;
                  if (w_new_wr) r_wline <= d_wdata;
               end
            end
            RD_CMD: r_count <= '0;
            RD_BURST: begin
               if (w_beat_ok) begin
                  r_line[r_count*BEAT_W +: BEAT_W] <= dfp_rdata;
                  r_count <= r_count + 1'b1;
               end
            end
            WR_BURST: begin
               if (dfp_ready) r_count <= r_count + 1'b1;
            end
            RESP: r_last <= r_grant;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: reads, writes, arbitration,
// stalls, stale beats and mid-burst reset.
module tb_cacheline_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  i_addr, d_addr, dfp_addr, dfp_raddr;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic [255:0] i_rdata, d_rdata, d_wdata;
   logic         dfp_read, dfp_write, dfp_ready, dfp_rvalid;
   logic [63:0]  dfp_wdata, dfp_rdata;

   int total = 0;
   int bad   = 0;
   int rd_cmds = 0;

   always #5 clk = ~clk;

   cacheline_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
      .dfp_wdata(dfp_wdata), .dfp_ready(dfp_ready), .dfp_raddr(dfp_raddr),
      .dfp_rdata(dfp_rdata), .dfp_rvalid(dfp_rvalid)
   );

   // Count memory read command cycles.
   always @(posedge clk) if (dfp_read) rd_cmds <= rd_cmds + 1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   function automatic logic [63:0] bd(input logic [31:0] a, input int k);
      return {a, 32'hB000_0000 + 32'(k)};
   endfunction

   function automatic logic [255:0] ln(input logic [31:0] a);
      return {bd(a, 3), bd(a, 2), bd(a, 1), bd(a, 0)};
   endfunction

   task automatic beat(input logic [31:0] a, input logic [63:0] d);
      dfp_rvalid = 1'b1; dfp_raddr = a; dfp_rdata = d;
      tick;
      dfp_rvalid = 1'b0; dfp_rdata = '0;
   endtask

   task automatic rd_beats(input logic [31:0] a);
      for (int k = 0; k < 4; k++) beat(a, bd(a, k));
   endtask

   logic [255:0] wl;
   int           rd0;

   initial begin
      rst = 1'b1; i_addr = '0; i_read = 0; d_addr = '0; d_read = 0; d_write = 0;
      d_wdata = '0; dfp_ready = 1'b1; dfp_raddr = '0; dfp_rdata = '0; dfp_rvalid = 0;
      tick; tick;
      chk("rst_i_resp", i_resp, 0);
      chk("rst_d_resp", d_resp, 0);
      chk("rst_dfp_read", dfp_read, 0);
      chk("rst_dfp_write", dfp_write, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      rst = 1'b0;

      // single icache read, 7-cycle minimum latency
      i_addr = 32'h1000_0024; i_read = 1;
      tick;
      chk("t1_cmd_read", dfp_read, 1);
      chk("t1_cmd_addr", dfp_addr, 32'h1000_0020);
      tick;
      chk("t1_burst_read", dfp_read, 0);
      rd_beats(32'h1000_0020);
      chk("t1_i_resp", i_resp, 1);
      chk("t1_i_rdata", i_rdata, ln(32'h1000_0020));
      chk("t1_d_resp", d_resp, 0);
      i_read = 0;
      tick;
      chk("t1_resp_pulse", i_resp, 0);
      chk("t1_one_cmd", 32'(rd_cmds), 1);

      // tie after reset: dcache first, then icache
      rst = 1; tick; rst = 0;
      i_addr = 32'h3000_0000; d_addr = 32'h4000_0044; i_read = 1; d_read = 1;
      tick;
      chk("t2_d_first", dfp_addr, 32'h4000_0040);
      tick;
      rd_beats(32'h4000_0040);
      chk("t2_d_resp", d_resp, 1);
      chk("t2_i_noresp", i_resp, 0);
      chk("t2_d_rdata", d_rdata, ln(32'h4000_0040));
      chk("t2_i_rdata0", i_rdata, 0);
      d_read = 0;
      tick;
      chk("t2_idle", dfp_read, 0);
      tick;
      chk("t2_i_cmd", dfp_read, 1);
      chk("t2_i_addr", dfp_addr, 32'h3000_0000);
      tick;
      rd_beats(32'h3000_0000);
      chk("t2_i_resp", i_resp, 1);
      chk("t2_i_line", i_rdata, ln(32'h3000_0000));
      i_read = 0;
      tick;

      // both held: grants alternate D,I,D,I
      i_read = 1; d_read = 1;
      for (int n = 0; n < 4; n++) begin
         logic [31:0] ea;
         ea = (n % 2 == 0) ? 32'h4000_0040 : 32'h3000_0000;
         tick;
         chk($sformatf("t2_alt%0d_addr", n), dfp_addr, ea);
         tick;
         rd_beats(ea);
         chk($sformatf("t2_alt%0d_dresp", n), d_resp, (n % 2 == 0) ? 1 : 0);
         chk($sformatf("t2_alt%0d_iresp", n), i_resp, (n % 2 == 0) ? 0 : 1);
         tick;
      end
      i_read = 0; d_read = 0;
      tick;

      // dcache write with ready stalls on beats 1 and 3
      wl = {64'h3333_3333_0000_0003, 64'h2222_2222_0000_0002,
            64'h1111_1111_0000_0001, 64'h0000_0000_0000_0010};
      d_addr = 32'h2000_0040; d_write = 1; d_wdata = wl; dfp_ready = 1;
      tick;
      d_wdata = {4{64'hBAD0_BAD0_BAD0_BAD0}};
      chk("t3_write", dfp_write, 1);
      chk("t3_addr", dfp_addr, 32'h2000_0040);
      chk("t3_w0", dfp_wdata, wl[63:0]);
      tick;
      chk("t3_w1", dfp_wdata, wl[127:64]);
      dfp_ready = 0;
      tick; chk("t3_w1_hold_a", dfp_wdata, wl[127:64]);
      tick; chk("t3_w1_hold_b", dfp_wdata, wl[127:64]);
      dfp_ready = 1;
      tick; chk("t3_w2", dfp_wdata, wl[191:128]);
      tick; chk("t3_w3", dfp_wdata, wl[255:192]);
      dfp_ready = 0;
      tick; chk("t3_w3_hold_a", dfp_wdata, wl[255:192]);
      chk("t3_noresp_early", d_resp, 0);
      tick; chk("t3_w3_hold_b", dfp_wdata, wl[255:192]);
      dfp_ready = 1;
      tick;
      chk("t3_d_resp", d_resp, 1);
      chk("t3_write_drop", dfp_write, 0);
      chk("t3_rdata0", d_rdata, 0);
      d_write = 0;
      tick;
      chk("t3_resp_pulse", d_resp, 0);

      // read with rvalid gaps and a mismatched beat; t=0 is the grant cycle
      i_addr = 32'h5000_0000; i_read = 1;
      tick;                                            // +1 RD_CMD
      tick;                                            // +2
      beat(32'h5000_0000, bd(32'h5000_0000, 0));       // +3
      beat(32'h5000_0020, 64'hDEAD_BEEF_DEAD_BEEF);    // +4
      tick;                                            // +5
      beat(32'h5000_0000, bd(32'h5000_0000, 1));       // +6
      beat(32'h5000_0000, bd(32'h5000_0000, 2));       // +7
      tick; tick;                                      // +9
      chk("t4_wait_noresp", i_resp, 0);
      tick;                                            // +10
      beat(32'h5000_0000, bd(32'h5000_0000, 3));       // +11
      chk("t4_resp_at_11", i_resp, 1);
      chk("t4_line", i_rdata, ln(32'h5000_0000));
      i_read = 0;
      tick;

      // reset during beat 2 of a dcache read
      d_addr = 32'h6000_0000; d_read = 1;
      tick; tick;
      beat(32'h6000_0000, bd(32'h6000_0000, 0));
      beat(32'h6000_0000, bd(32'h6000_0000, 1));
      rst = 1;
      beat(32'h6000_0000, bd(32'h6000_0000, 2));
      chk("t5_d_resp0", d_resp, 0);
      chk("t5_read0", dfp_read, 0);
      chk("t5_write0", dfp_write, 0);
      chk("t5_addr0", dfp_addr, 0);
      chk("t5_rdata0", d_rdata, 0);
      rst = 0; d_read = 0;
      beat(32'h6000_0000, bd(32'h6000_0000, 3));
      tick;
      chk("t5_stale_noresp", d_resp, 0);
      chk("t5_stale_idle", dfp_read, 0);
      // new icache read; a stray beat during RD_CMD must be ignored
      i_addr = 32'h7000_0008; i_read = 1; dfp_ready = 0;
      tick;
      chk("t5_cmd", dfp_read, 1);
      beat(32'h7000_0000, 64'hDEAD_0000_DEAD_0000);
      chk("t5_cmd_hold", dfp_read, 1);
      dfp_ready = 1;
      tick;
      rd_beats(32'h7000_0000);
      chk("t5_i_resp", i_resp, 1);
      chk("t5_i_line", i_rdata, ln(32'h7000_0000));
      i_read = 0;
      tick;

      // read+write together becomes a write burst
      rd0 = rd_cmds;
      d_addr = 32'h8000_0000; d_read = 1; d_write = 1; d_wdata = ~wl;
      tick;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t6_write%0d", k), dfp_write, 1);
         chk($sformatf("t6_noread%0d", k), dfp_read, 0);
         chk($sformatf("t6_wdata%0d", k), dfp_wdata, (~wl) >> (64 * k) & 256'hFFFF_FFFF_FFFF_FFFF);
         tick;
      end
      chk("t6_d_resp", d_resp, 1);
      chk("t6_no_rd_cmd", 32'(rd_cmds - rd0), 0);
      d_read = 0; d_write = 0;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
